// File: rtl/alu_pkg.sv
// Shared types and constants for the 16-bit add/sub ALU front-end.
package alu_pkg;

  localparam int ALU_W       = 16;
  localparam int CMD_OP_BIT  = 0;
  localparam int CMD_ACC_BIT = 1;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [2:0] {
    CMD    = 3'd0,
    A_LO   = 3'd1,
    A_HI   = 3'd2,
    B_LO   = 3'd3,
    B_HI   = 3'd4,
    EXEC   = 3'd5,
    RESULT = 3'd6
  } state_t;

  typedef struct packed {
    logic acc_src;
    logic op;
  } cmd_t;

  // Only the two low command bits carry meaning; the rest are ignored.
  function automatic cmd_t decode_cmd(input logic [1:0] c);
    cmd_t r;
    r.op      = c[CMD_OP_BIT];
    r.acc_src = c[CMD_ACC_BIT];
    return r;
  endfunction

endpackage

// File: rtl/alu_add_sub.sv
// Purely combinational add/sub ALU; instanced beside the sequencer.
module alu_add_sub
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] s
);

  // Result wraps modulo 2^W; no carry/borrow out.
  always_comb begin
    s = (op == OP_ADD) ? (a + b) : (a - b);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Byte-stream front-end: assembles A/B/op for the ALU, captures the result
// into an accumulator and offers it on a valid/ready result port.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_op,
  input  logic [DATA_W-1:0] alu_s,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              rv_q, rv_d;
  // Holds in_ready low until the first edge after reset release.
  logic              en_q;
  logic              load_st;
  logic              accept;
  cmd_t              cmd;

  assign cmd     = decode_cmd(in_data[1:0]);
  assign load_st = (state_q == CMD)  || (state_q == A_LO) || (state_q == A_HI) ||
                   (state_q == B_LO) || (state_q == B_HI);
  assign in_ready = en_q && load_st;
  assign accept   = in_valid && in_ready;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign res_data  = res_q;
  assign res_valid = rv_q;
  assign busy      = (state_q != CMD);

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    acc_d   = acc_q;
    rv_d    = rv_q;
    case (state_q)
      CMD: if (accept) begin
        op_d = cmd.op;
        if (cmd.acc_src) begin
          a_d     = acc_q;
          state_d = B_LO;
        end else begin
          state_d = A_LO;
        end
      end
      A_LO: if (accept) begin
        a_d[BYTE_W-1:0] = in_data;
        state_d         = A_HI;
      end
      A_HI: if (accept) begin
        a_d[DATA_W-1:BYTE_W] = in_data;
        state_d              = B_LO;
      end
      B_LO: if (accept) begin
        b_d[BYTE_W-1:0] = in_data;
        state_d         = B_HI;
      end
      B_HI: if (accept) begin
        b_d[DATA_W-1:BYTE_W] = in_data;
        state_d              = EXEC;
      end
      // Operands have been stable for a full cycle; sample the ALU.
      EXEC: begin
        res_d   = alu_s;
        acc_d   = alu_s;
        rv_d    = 1'b1;
        state_d = RESULT;
      end
      RESULT: if (res_ready) begin
        rv_d    = 1'b0;
        state_d = CMD;
      end
      default: state_d = CMD;
    endcase
  end

  // State and datapath registers; reset discards any partial or pending op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CMD;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      acc_q   <= '0;
      rv_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      rv_q    <= rv_d;
      en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with the ALU instanced beside it.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_a, alu_b, alu_s, res_data;
  logic        alu_op, res_valid, busy;
  logic        res_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int taken  = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  alu_add_sub #(.W(16)) u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .s(alu_s));

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) taken++;
    if (rst_n && res_valid && res_ready) xfers++;
  end

  // Present one byte, wait (bounded) for acceptance, then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    int t0;
    logic [15:0] a0, b0;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte timeout in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (gap > 0) begin
      t0 = taken; a0 = alu_a; b0 = alu_b;
      repeat (gap) @(negedge clk);
      checks++;
      if (taken !== t0 || alu_a !== a0 || alu_b !== b0) begin
        errors++;
        $display("FAIL bubble_no_take taken %0d->%0d a %h->%h b %h->%h required unchanged",
                 t0, taken, a0, alu_a, b0, alu_b);
      end
    end
  endtask

  // Called right after the last operand byte: checks 2-edge latency and value.
  task automatic check_result(input string name, input logic [15:0] exp);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid res_valid=%0b required 0", name, res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp) begin
      errors++;
      $display("FAIL %s result valid=%0b data=%h required 1 %h", name, res_valid, res_data, exp);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release valid=%0b busy=%0b in_ready=%0b required 0 0 1",
               name, res_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || res_data !== 0 ||
        in_ready !== 0 || res_valid !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL reset_outputs a=%h b=%h op=%0b r=%h rdy=%0b rv=%0b busy=%0b required all 0",
               alu_a, alu_b, alu_op, res_data, in_ready, res_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low in_ready=%0b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    send_byte(8'h01, 0); send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h0F, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || res_data !== 0 ||
        in_ready !== 0 || res_valid !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL midop_reset a=%h b=%h op=%0b r=%h rdy=%0b rv=%0b busy=%0b required all 0",
               alu_a, alu_b, alu_op, res_data, in_ready, res_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midop_after rv=%0b busy=%0b required 0 0", res_valid, busy);
      end
    end
    // acc must be 0: acc_src add with B=0 yields A=acc.
    send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++;
    if (alu_a !== 16'h0000) begin
      errors++;
      $display("FAIL midop_acc_zero alu_a=%h required 0000", alu_a);
    end
    check_result("midop_acc", 16'h0000);
  endtask

  task automatic test_add(input int gap, input string name);
    int t0;
    t0 = taken;
    send_byte(8'h01, gap); send_byte(8'h34, gap); send_byte(8'h12, gap);
    send_byte(8'h0F, gap); send_byte(8'h0F, 0);
    checks++;
    if (alu_a !== 16'h1234 || alu_b !== 16'h0F0F || alu_op !== OP_ADD || taken - t0 != 5) begin
      errors++;
      $display("FAIL %s operands a=%h b=%h op=%0b bytes=%0d required 1234 0f0f 1 5",
               name, alu_a, alu_b, alu_op, taken - t0);
    end
    check_result(name, 16'h2143);
  endtask

  task automatic test_sub_wrap();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    checks++;
    if (alu_op !== OP_SUB || alu_b !== 16'h0001) begin
      errors++;
      $display("FAIL sub_operands op=%0b b=%h required 0 0001", alu_op, alu_b);
    end
    check_result("sub_wrap", 16'hFFFF);
  endtask

  task automatic test_accumulate();
    int t0;
    t0 = taken;
    send_byte(8'h03, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    checks++;
    if (alu_a !== 16'hFFFF || alu_b !== 16'h0001 || taken - t0 != 3) begin
      errors++;
      $display("FAIL accum_operands a=%h b=%h bytes=%0d required ffff 0001 3",
               alu_a, alu_b, taken - t0);
    end
    check_result("accumulate", 16'h0000);
  endtask

  task automatic test_backpressure();
    int n;
    int x0;
    res_ready = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
    send_byte(8'h07, 0); send_byte(8'h00, 0);
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    x0 = xfers;
    repeat (5) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h000C || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold rv=%0b data=%h rdy=%0b busy=%0b required 1 000c 0 1",
                 res_valid, res_data, in_ready, busy);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (xfers - x0 != 1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release xfers=%0d rv=%0b busy=%0b required 1 0 0",
               xfers - x0, res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_add(0, "add");
    test_sub_wrap();
    test_accumulate();
    test_backpressure();
    test_add(3, "bubbles");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
